// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port sequencer for the single-port RAM.
// Owns the tristate data bus and inserts a turnaround cycle per access.
module ram_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 64,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_isReading,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int CW =
    (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic              last_grant;
  logic              win;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;
  logic              drive;

  // Round-robin pick: lone requester wins, a tie goes
  // to the port that was not served last.
  always_comb begin
    win = 1'b0;
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n = we[win] ? WRITE : READ;
        end
      end
      WRITE: state_n = DONE;
      READ: begin
        if (cnt == '0) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grant bookkeeping, request latching, read wait
  // counter and read data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      rdata      <= '0;
    end else begin
      if (state == IDLE && |req) begin
        last_grant <= win;
        addr_q     <= win ? addr1 : addr0;
        wdata_q    <= win ? wdata1 : wdata0;
        cnt        <= CNT_LOAD;
      end
      if (state == READ) begin
        if (cnt == '0) begin
          rdata <= mem_data;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Outputs decoded from state: the bus is only driven
  // in WRITE, and DONE doubles as the turnaround cycle.
  always_comb begin
    ack           = '0;
    busy          = (state != IDLE);
    mem_isReading = (state != WRITE);
    drive         = (state == WRITE);
    if (state == DONE) begin
      ack[last_grant] = 1'b1;
    end
  end

  assign mem_address = addr_q;
  assign mem_data    = drive ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a
// behavioural single-port RAM on the tristate bus.
module tb_ram_arbiter;

  localparam int RL = 1;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [10:0] addr0;
  logic [10:0] addr1;
  logic [63:0] wdata0;
  logic [63:0] wdata1;
  logic [1:0]  ack;
  logic [63:0] rdata;
  logic        busy;
  logic [10:0] mem_address;
  logic        mem_isReading;
  wire  [63:0] mem_data;

  int tests;
  int fails;

  logic [63:0] mem [0:2047];

  ram_arbiter #(
    .ADDR_W(11),
    .DATA_W(64),
    .READ_LAT(RL)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .req(req),
    .we(we),
    .addr0(addr0),
    .addr1(addr1),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .ack(ack),
    .rdata(rdata),
    .busy(busy),
    .mem_address(mem_address),
    .mem_isReading(mem_isReading),
    .mem_data(mem_data)
  );

  assign mem_data =
    mem_isReading ? mem[mem_address] : 'z;

  always @(posedge clk) begin
    if (!mem_isReading) begin
      mem[mem_address] <= mem_data;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  typedef struct {
    int          port;
    logic        w;
    logic [10:0] a;
    logic [63:0] d;
    logic [63:0] er;
    logic        drop;
    string       nm;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic set_port(input int p,
                          input logic w,
                          input logic [10:0] a,
                          input logic [63:0] d);
    we[p] = w;
    if (p == 0) begin
      addr0  = a;
      wdata0 = d;
    end else begin
      addr1  = a;
      wdata1 = d;
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int wlo;
    int berr;
    logic [1:0] seen;
    logic [1:0] ea;
    set_port(v.port, v.w, v.a, v.d);
    req[v.port] = 1'b1;
    n = 0;
    wlo = 0;
    berr = 0;
    seen = '0;
    while (seen == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
      if (!mem_isReading) begin
        wlo++;
        if (mem_data != v.d) berr++;
      end else if (mem_data != mem[mem_address]) begin
        berr++;
      end
      if (n == 2) begin
        set_port(v.port, ~v.w, ~v.a, ~v.d);
        if (v.drop) req[v.port] = 1'b0;
      end
      seen = ack;
    end
    ea = 2'(1 << v.port);
    chk({v.nm, " lat"}, 64'(n - 1),
        v.w ? 64'd2 : 64'(RL + 1));
    chk({v.nm, " ack"}, 64'(seen), 64'(ea));
    chk({v.nm, " wr_cycles"}, 64'(wlo),
        v.w ? 64'd1 : 64'd0);
    chk({v.nm, " bus"}, 64'(berr), 64'd0);
    chk({v.nm, " busy"}, 64'(busy), 64'd1);
    chk({v.nm, " rdata"}, rdata, v.er);
    @(posedge clk);
    #1;
    req[v.port] = 1'b0;
  endtask

  task automatic wait_ack(output logic [1:0] a);
    int n;
    n = 0;
    a = '0;
    while (a == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
      a = ack;
    end
  endtask

  initial begin
    logic [1:0] a;
    int k;
    int n;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    end
    tbl[0] = '{0, 1'b1, 11'd1024, 64'hff04,
               64'h0, 1'b0, "w1024"};
    tbl[1] = '{0, 1'b0, 11'd1023, 64'h0,
               64'hA5A5_0000_0000_03FF, 1'b0, "r1023"};
    tbl[2] = '{0, 1'b0, 11'd1024, 64'h0,
               64'hff04, 1'b1, "r1024"};
    tbl[3] = '{1, 1'b1, 11'd0, '1,
               64'hff04, 1'b0, "w0"};
    tbl[4] = '{1, 1'b1, 11'd2047, 64'h0,
               64'hff04, 1'b0, "w2047"};
    tbl[5] = '{0, 1'b0, 11'd0, 64'h0,
               '1, 1'b0, "r0"};
    tbl[6] = '{1, 1'b0, 11'd2047, 64'h0,
               64'h0, 1'b0, "r2047"};
    tbl[7] = '{1, 1'b1, 11'd5,
               64'h0123_4567_89AB_CDEF,
               64'h0, 1'b1, "w5"};
    tbl[8] = '{1, 1'b0, 11'd5, 64'h0,
               64'h0123_4567_89AB_CDEF, 1'b0, "r5"};

    rst_n  = 1'b0;
    req    = '0;
    we     = '0;
    addr0  = '0;
    addr1  = '0;
    wdata0 = '0;
    wdata1 = '0;
    repeat (2) @(negedge clk);
    chk("rst ack", 64'(ack), 64'h0);
    chk("rst rdata", rdata, 64'h0);
    chk("rst busy", 64'(busy), 64'h0);
    chk("rst addr", 64'(mem_address), 64'h0);
    chk("rst isrd", 64'(mem_isReading), 64'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i]);
    end

    // both ports held: strict alternation from reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_port(0, 1'b0, 11'd1024, 64'h0);
    set_port(1, 1'b0, 11'd1023, 64'h0);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(a);
      chk($sformatf("alt%0d ack", i), 64'(a),
          (i % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("alt%0d rdata", i), rdata,
          (i % 2 == 0) ? 64'hff04
                       : 64'hA5A5_0000_0000_03FF);
    end
    @(posedge clk);
    #1;
    req = 2'b00;

    // port1 streams, port0 joins mid-transaction
    set_port(1, 1'b0, 11'd5, 64'h0);
    set_port(0, 1'b0, 11'd0, 64'h0);
    req = 2'b10;
    wait_ack(a);
    chk("fair first", 64'(a), 64'h2);
    @(posedge clk);
    @(posedge clk);
    #1;
    req[0] = 1'b1;
    k = 0;
    wait_ack(a);
    while (a == 2'b10 && k < 3) begin
      k++;
      wait_ack(a);
    end
    chk("fair p0 ack", 64'(a), 64'h1);
    chk("fair wait", 64'(k <= 1), 64'h1);
    chk("fair rdata", rdata, '1);
    @(posedge clk);
    #1;
    req = 2'b00;
    @(posedge clk);
    #1;

    // async reset in the middle of a write
    set_port(0, 1'b1, 11'd9, 64'h5555);
    req[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (mem_isReading && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid write seen", 64'(mem_isReading), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst isrd", 64'(mem_isReading), 64'h1);
    chk("mid rst ack", 64'(ack), 64'h0);
    chk("mid rst busy", 64'(busy), 64'h0);
    chk("mid rst addr", 64'(mem_address), 64'h0);
    chk("mid rst bus", mem_data, '1);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn('{1, 1'b0, 11'd2047, 64'h0,
              64'h0, 1'b0, "post r2047"});

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
